ps2_kbd_ctrl: RTL and testbench
===============================

// Module: ps2_kbd_ctrl
// PURPOSE
//  Sequencer that sits between the ps2_keyboard core and the rest of the design.
//  After reset it initialises the keyboard: 0xFF reset, wait for ACK, then wait for the BAT result.
//  It then decodes set-2 scancodes (E0/F0 prefixes) into single-cycle key events.
//  It also drives the keyboard LEDs (0xED + mask) with ACK checking, resend handling and retry-limited timeouts.
// PARAMETERS
//  ACK_TIMEOUT  2500000   cycles to wait for 0xFA after a byte is sent (50 ms @ 50 MHz)
//  BAT_TIMEOUT  50000000  cycles to wait for 0xAA after the reset ACK (1 s)
//  MAX_RETRY    3         failed attempts per byte before entering ERROR
// PORTS
//  CLOCK_50       in   1  system clock; all logic on posedge
//  reset          in   1  synchronous, active-high
//  the_command    out  8  byte to transmit; to ps2_keyboard.the_command
//  send_command   out  1  transmit request; to ps2_keyboard.send_command
//  command_was_sent                in  1  core: byte transmitted
//  error_communication_timed_out   in  1  core: transmit failed
//  received_data     in   8  core: received byte
//  received_data_en  in   1  core: received_data valid, one cycle
//  led_state      in   3  {caps, num, scroll} requested LED mask
//  led_update     in   1  pulse: apply led_state
//  key_code       out  8  scancode of last event (held until next event)
//  key_ext        out  1  event was E0-prefixed
//  key_release    out  1  event was F0-prefixed (break)
//  key_valid      out  1  one-cycle strobe; key_* valid in the same cycle
//  kbd_ready      out  1  1 in IDLE only
//  kbd_error      out  1  1 in ERROR only
// BEHAVIOUR
//  - Reset values:
//    - All outputs are 0: the_command=8'h00, send_command=0, key_*=0, kbd_ready=0, kbd_error=0.
//    - Retry count, timer, prefix flags and led_pending are cleared.
//    - FSM enters RST_TX.
//    - Reset mid-transfer drops send_command in the next cycle; no byte is resumed.
//  - Transmit handshake:
//    - Drive the_command, then hold send_command=1 until command_was_sent or error_communication_timed_out.
//    - Then send_command=0 for at least 1 cycle before the next request.
//    - the_command is stable for the whole time send_command=1.
//  - FSM states and transitions:
//    - RST_TX: send 8'hFF, then go to RST_ACK.
//    - RST_ACK: wait for 8'hFA, then go to BAT.
//    - BAT: on 8'hAA go to LED_TX (pushes the current mask); on 8'hFC go to ERROR.
//    - IDLE: scancode decode; LED sequence start.
//    - LED_TX: send 8'hED, then go to LED_ACK1.
//    - LED_ACK1: wait for 8'hFA, then go to MSK_TX.
//    - MSK_TX: send {5'b0, led_state latched}, then go to LED_ACK2.
//    - LED_ACK2: wait for 8'hFA, then go to IDLE.
//    - ERROR: kbd_error=1; leaves only on reset or a received 8'hAA (hot-plug), then goes to LED_TX.
//  - ACK states:
//    - A timer counts from the cycle send_command drops.
//    - 8'hFE (resend), a core transmit timeout, or timer expiry each count one retry and re-send the same byte.
//    - After MAX_RETRY failures on one byte the FSM goes to ERROR.
//    - The retry count clears when a byte is ACKed.
//    - Other bytes received while waiting are discarded and never reported as keys.
//  - BAT state: expiry of BAT_TIMEOUT counts as a retry of the 8'hFF.
//  - IDLE decode of received bytes:
//    - E0 sets ext.
//    - F0 sets rel.
//    - 00/FF (overrun) clears both flags with no event.
//    - AA clears both flags and sets led_pending.
//    - Any other byte: next cycle key_valid=1, key_code=byte, key_ext=ext, key_release=rel; flags then clear.
//    - Latency is 1 cycle from received_data_en to key_valid.
//  - led_update:
//    - Sets led_pending and latches led_state in any state; a later pulse overwrites the mask.
//    - In IDLE with led_pending=1 and no decode in progress, go to LED_TX.
//    - If led_update and received_data_en coincide in IDLE: the byte is decoded first, then LED_TX starts next cycle.
//    - led_pending clears on entry to LED_TX.
//    - Prefix flags persist across an LED sequence.
// CONFIGURATION
//  PS2_KBD_LOCKS_EN defined:
//   - Non-extended make codes 58 (caps), 77 (num) and 7E (scroll) toggle internal lock bits and set led_pending.
//   - The mask sent is the lock bits OR led_state.
//   - Break codes and repeats while held do not toggle.
//  PS2_KBD_LOCKS_EN undefined:
//   - No lock tracking; the LED mask comes only from led_state/led_update.
// TESTING
//  1. Init: release reset; BFM ACKs FF with FA, then sends AA.
//     -> TX order is FF, ED, 00; kbd_ready=1 after the final FA.
//  2. In IDLE, rx E0 F0 75.
//     -> exactly one key_valid with key_code=8'h75, key_ext=1, key_release=1; then rx 1C -> 1C, ext=0, rel=0.
//  3. led_state=3'b101 with led_update pulse.
//     -> TX ED then 05; a BFM FE reply to 05 causes one re-send of 05; kbd_ready drops and returns to 1.
//  4. BFM never ACKs the FF.
//     -> FF is sent exactly MAX_RETRY times at ACK_TIMEOUT spacing; kbd_error=1; an rx AA then gives TX ED.
//  5. led_update pulses twice during the init sequence (masks 001 then 110).
//     -> exactly one LED sequence after init, with mask 06.
//  6. (PS2_KBD_LOCKS_EN) rx 58, F0 58, 58.
//     -> masks 04 then 00 sent; without the macro no TX occurs.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: resets the keyboard, waits for BAT, decodes set-2
// scancodes into single-cycle key events and drives the keyboard LEDs.
// Optional feature macro: PS2_KBD_LOCKS_EN (caps/num/scroll lock tracking).
module ps2_kbd_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 2500000,
  parameter int unsigned BAT_TIMEOUT = 50000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic [2:0] led_state,
  input  logic       led_update,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic       kbd_ready,
  output logic       kbd_error
);

  typedef enum logic [3:0] {
    StRstTx, StRstAck, StBat, StIdle, StLedTx, StLedAck1, StMskTx, StLedAck2, StError
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        send_q, send_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic        ext_q, ext_d, rel_q, rel_d;
  logic        pending_q, pending_d;
  logic [2:0]  mask_q, mask_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_ext_q, key_ext_d, key_rel_q, key_rel_d, key_valid_q, key_valid_d;

  logic [2:0]  led_mask;
  logic [7:0]  tx_byte;
  state_e      ack_next, resend_st;
  logic        fail;
  state_e      retry_st;

`ifdef PS2_KBD_LOCKS_EN
  logic [2:0] lock_q, lock_d, held_q, held_d, lock_sel;

  // Map the lock make codes onto the {caps, num, scroll} bit positions.
  always_comb begin
    lock_sel = 3'b000;
    case (received_data)
      8'h58:   lock_sel = 3'b100;
      8'h77:   lock_sel = 3'b010;
      8'h7E:   lock_sel = 3'b001;
      default: lock_sel = 3'b000;
    endcase
  end

  assign led_mask = mask_q | lock_q;
`else
  assign led_mask = mask_q;
`endif

  // Per-state byte to send, state after a good ACK, and state to re-send from.
  always_comb begin
    tx_byte   = 8'hFF;
    ack_next  = StBat;
    resend_st = StRstTx;
    case (state_q)
      StRstTx, StRstAck: begin
        tx_byte = 8'hFF; ack_next = StBat; resend_st = StRstTx;
      end
      StLedTx, StLedAck1: begin
        tx_byte = 8'hED; ack_next = StMskTx; resend_st = StLedTx;
      end
      StMskTx, StLedAck2: begin
        tx_byte = {5'b0, led_mask}; ack_next = StIdle; resend_st = StMskTx;
      end
      default: ;
    endcase
  end

  // Next-state, transmit handshake, retry accounting and scancode decode.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    send_d      = send_q;
    timer_d     = '0;
    retry_d     = retry_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    pending_d   = pending_q;
    mask_d      = mask_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    key_valid_d = 1'b0;
    fail        = 1'b0;
    retry_st    = state_q;
`ifdef PS2_KBD_LOCKS_EN
    lock_d      = lock_q;
    held_d      = held_q;
`endif
    case (state_q)
      StRstTx, StLedTx, StMskTx: begin
        if (!send_q) begin
          send_d = 1'b1;
          cmd_d  = tx_byte;
        end else if (command_was_sent) begin
          send_d  = 1'b0;
          state_d = ack_next == StBat ? StRstAck
                  : (ack_next == StMskTx ? StLedAck1 : StLedAck2);
        end else if (error_communication_timed_out) begin
          send_d = 1'b0;
          fail   = 1'b1;
        end
      end
      StRstAck, StLedAck1, StLedAck2: begin
        timer_d = timer_q + 32'd1;
        if (received_data_en && received_data == 8'hFA) begin
          retry_d = '0;
          timer_d = '0;
          state_d = ack_next;
        end else if ((received_data_en && received_data == 8'hFE) ||
                     timer_q >= 32'(ACK_TIMEOUT - 1)) begin
          fail     = 1'b1;
          retry_st = resend_st;
        end
      end
      StBat: begin
        timer_d = timer_q + 32'd1;
        if (received_data_en && received_data == 8'hAA) begin
          state_d   = StLedTx;
          pending_d = 1'b0;
        end else if (received_data_en && received_data == 8'hFC) begin
          state_d = StError;
        end else if (timer_q >= 32'(BAT_TIMEOUT - 1)) begin
          fail     = 1'b1;
          retry_st = StRstTx;
        end
      end
      StIdle: begin
        if (received_data_en) begin
          case (received_data)
            8'hE0: ext_d = 1'b1;
            8'hF0: rel_d = 1'b1;
            8'h00, 8'hFF: begin
              ext_d = 1'b0; rel_d = 1'b0;
            end
            8'hAA: begin
              ext_d = 1'b0; rel_d = 1'b0; pending_d = 1'b1;
            end
            default: begin
              key_valid_d = 1'b1;
              key_code_d  = received_data;
              key_ext_d   = ext_q;
              key_rel_d   = rel_q;
              ext_d       = 1'b0;
              rel_d       = 1'b0;
`ifdef PS2_KBD_LOCKS_EN
              // Toggle only on the first make; typematic repeats keep held set.
              if (!ext_q) begin
                if (rel_q) begin
                  held_d = held_q & ~lock_sel;
                end else if ((lock_sel & ~held_q) != 3'b000) begin
                  lock_d    = lock_q ^ lock_sel;
                  held_d    = held_q | lock_sel;
                  pending_d = 1'b1;
                end
              end
`endif
            end
          endcase
        end else if (pending_q) begin
          state_d   = StLedTx;
          pending_d = 1'b0;
        end
      end
      StError: begin
        if (received_data_en && received_data == 8'hAA) begin
          state_d   = StLedTx;
          pending_d = 1'b0;
        end
      end
      default: state_d = StRstTx;
    endcase
    if (fail) begin
      timer_d = '0;
      if (32'(retry_q) + 32'd1 >= MAX_RETRY) begin
        retry_d = '0;
        state_d = StError;
      end else begin
        retry_d = retry_q + 8'd1;
        state_d = retry_st;
      end
    end
    // A later pulse overwrites the mask; it is honoured whatever the state.
    if (led_update) begin
      pending_d = 1'b1;
      mask_d    = led_state;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StRstTx;
      cmd_q       <= 8'h00;
      send_q      <= 1'b0;
      timer_q     <= '0;
      retry_q     <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      pending_q   <= 1'b0;
      mask_q      <= 3'b000;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef PS2_KBD_LOCKS_EN
      lock_q      <= 3'b000;
      held_q      <= 3'b000;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      send_q      <= send_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      key_valid_q <= key_valid_d;
`ifdef PS2_KBD_LOCKS_EN
      lock_q      <= lock_d;
      held_q      <= held_d;
`endif
    end
  end

  assign the_command  = cmd_q;
  assign send_command = send_q;
  assign key_code     = key_code_q;
  assign key_ext      = key_ext_q;
  assign key_release  = key_rel_q;
  assign key_valid    = key_valid_q;
  assign kbd_ready    = (state_q == StIdle);
  assign kbd_error    = (state_q == StError);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a core/keyboard BFM answers transmitted
// bytes, monitors pop expected TX bytes and key events from queues.
module tb_ps2_kbd_ctrl;
  localparam int unsigned AckTo = 40;
  localparam int unsigned BatTo = 200;
  localparam int unsigned MaxRetry = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [2:0] led_state;
  logic       led_update;
  logic [7:0] key_code;
  logic       key_ext, key_release, key_valid, kbd_ready, kbd_error;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(
    .ACK_TIMEOUT(AckTo),
    .BAT_TIMEOUT(BatTo),
    .MAX_RETRY  (MaxRetry)
  ) dut (
    .CLOCK_50                      (clk),
    .reset                         (reset),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .led_state                     (led_state),
    .led_update                    (led_update),
    .key_code                      (key_code),
    .key_ext                       (key_ext),
    .key_release                   (key_release),
    .key_valid                     (key_valid),
    .kbd_ready                     (kbd_ready),
    .kbd_error                     (kbd_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_tx[$];
  logic [10:0] exp_key[$];   // {ext, rel, code}
  logic [7:0]  rx_q[$];

  bit         no_ack = 1'b0;
  bit         auto_bat = 1'b1;
  logic [7:0] fe_byte = 8'h00;
  int         fe_left = 0;
  int         last_rx_cyc = -10;
  int         fall_cyc = 0;
  int         last_gap = 0;
  int         ff_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core + keyboard model: sole driver of the core-side inputs.
  initial begin
    int gap = 0;
    int tx_cnt = 0;
    bit in_tx = 1'b0;
    logic [7:0] b;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    received_data = 8'h00;
    received_data_en = 1'b0;
    forever begin
      @(negedge clk);
      command_was_sent = 1'b0;
      received_data_en = 1'b0;
      if (reset) begin
        in_tx = 1'b0;
      end else if (send_command) begin
        if (!in_tx) begin
          in_tx = 1'b1;
          tx_cnt = 0;
        end
        tx_cnt++;
        if (tx_cnt == 3) begin
          command_was_sent = 1'b1;
          b = the_command;
          if (!no_ack) begin
            if (fe_left > 0 && b == fe_byte) begin
              rx_q.push_back(8'hFE);
              fe_left--;
            end else begin
              rx_q.push_back(8'hFA);
              if (b == 8'hFF && auto_bat) rx_q.push_back(8'hAA);
            end
            if (gap < 3) gap = 3;
          end
        end
      end else begin
        in_tx = 1'b0;
      end
      if (gap > 0) begin
        gap--;
      end else if (rx_q.size() > 0) begin
        received_data = rx_q.pop_front();
        received_data_en = 1'b1;
        last_rx_cyc = cyc;
        gap = 4;
      end
    end
  end

  // TX monitor: byte order, stability while requested, spacing between sends.
  initial begin
    logic prev_send = 1'b0;
    logic [7:0] held_cmd = 8'h00;
    bit stable_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (send_command && !prev_send) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected none", the_command);
        end else begin
          check("tx_byte", {24'b0, the_command}, {24'b0, exp_tx.pop_front()});
        end
        held_cmd = the_command;
        stable_bad = 1'b0;
        last_gap = cyc - fall_cyc;
        if (the_command == 8'hFF) ff_count++;
      end else if (send_command && the_command !== held_cmd) begin
        stable_bad = 1'b1;
      end
      if (!send_command && prev_send) begin
        check("tx_stable", {31'b0, stable_bad}, 32'd0);
        fall_cyc = cyc;
      end
      prev_send = send_command;
    end
  end

  // Key event monitor.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        if (exp_key.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_unexpected: got %0h expected none", key_code);
        end else begin
          e = exp_key.pop_front();
          check("key_code", {24'b0, key_code}, {24'b0, e[7:0]});
          check("key_ext", {31'b0, key_ext}, {31'b0, e[10]});
          check("key_release", {31'b0, key_release}, {31'b0, e[8]});
          check("key_latency", cyc, last_rx_cyc + 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int i = 0;
    while (!kbd_ready && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'b0, kbd_ready}, 32'd1);
  endtask

  task automatic drain_rx();
    int i = 0;
    while (rx_q.size() > 0 && i < 500) begin
      @(negedge clk);
      i++;
    end
    tick(3);
  endtask

  task automatic pulse_led(input logic [2:0] m);
    led_state = m;
    led_update = 1'b1;
    @(negedge clk);
    led_update = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] code, input logic ext, input logic rel);
    exp_key.push_back({ext, 1'b0, rel, code} & 11'h5FF | {ext, 10'b0});
  endtask

  initial begin
    int i;
    reset = 1'b1;
    led_state = 3'b000;
    led_update = 1'b0;
    tick(4);
    check("rst_command", {24'b0, the_command}, 32'h00);
    check("rst_send", {31'b0, send_command}, 32'd0);
    check("rst_key_valid", {31'b0, key_valid}, 32'd0);
    check("rst_ready", {31'b0, kbd_ready}, 32'd0);
    check("rst_error", {31'b0, kbd_error}, 32'd0);

    // Init: FF, ED, 00.
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h00);
    reset = 1'b0;
    wait_ready("init_ready", 2000);

    // Prefixed break then a plain make.
    push_key(8'h75, 1'b1, 1'b1);
    push_key(8'h1C, 1'b0, 1'b0);
    rx_q.push_back(8'hE0);
    rx_q.push_back(8'hF0);
    rx_q.push_back(8'h75);
    rx_q.push_back(8'h1C);
    drain_rx();
    tick(5);

    // LED update with one resend of the mask byte.
    fe_byte = 8'h05;
    fe_left = 1;
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h05);
    exp_tx.push_back(8'h05);
    pulse_led(3'b101);
    i = 0;
    while (kbd_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("led_busy", {31'b0, kbd_ready}, 32'd0);
    wait_ready("led_ready", 2000);

    // Clear mask, then lock keys.
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h00);
    pulse_led(3'b000);
    tick(3);
    wait_ready("mask_clear_ready", 2000);
`ifdef PS2_KBD_LOCKS_EN
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h04);
`endif
    push_key(8'h58, 1'b0, 1'b0);
    rx_q.push_back(8'h58);
    drain_rx();
    wait_ready("lock1_ready", 2000);
    push_key(8'h58, 1'b0, 1'b1);
    rx_q.push_back(8'hF0);
    rx_q.push_back(8'h58);
    drain_rx();
    wait_ready("lock2_ready", 2000);
`ifdef PS2_KBD_LOCKS_EN
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h00);
`endif
    push_key(8'h58, 1'b0, 1'b0);
    rx_q.push_back(8'h58);
    drain_rx();
    wait_ready("lock3_ready", 2000);
    tick(20);

    // Keyboard never ACKs the reset byte.
    no_ack = 1'b1;
    reset = 1'b1;
    tick(3);
    ff_count = 0;
    for (int k = 0; k < int'(MaxRetry); k++) exp_tx.push_back(8'hFF);
    reset = 1'b0;
    i = 0;
    while (!kbd_error && i < int'((AckTo + 20) * MaxRetry + 50)) begin
      @(negedge clk);
      i++;
    end
    check("noack_error", {31'b0, kbd_error}, 32'd1);
    check("noack_ff_count", ff_count, MaxRetry);
    check("noack_gap", {31'b0, (last_gap >= int'(AckTo) && last_gap <= int'(AckTo) + 2)}, 32'd1);
    tick(10);
    check("error_holds", {31'b0, kbd_error}, 32'd1);
    no_ack = 1'b0;
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h00);
    rx_q.push_back(8'hAA);
    wait_ready("hotplug_ready", 2000);
    check("hotplug_error_clear", {31'b0, kbd_error}, 32'd0);

    // Two LED updates during init collapse into one sequence with the last mask.
    reset = 1'b1;
    tick(3);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h06);
    reset = 1'b0;
    tick(2);
    pulse_led(3'b001);
    tick(2);
    pulse_led(3'b110);
    wait_ready("init2_ready", 2000);
    tick(100);
    check("init2_stays_ready", {31'b0, kbd_ready}, 32'd1);

    check("tx_queue_empty", exp_tx.size(), 32'd0);
    check("key_queue_empty", exp_key.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
